// File: rtl/round_controller.sv
// Round sequencing for a two-player duel: waits for start, runs play,
// plays an explosion animation when a player is struck, holds a respawn
// pause, and declares a winner once a score reaches WIN_SCORE.
//
// Handshake note: this block has no valid/ready channels. start and
// frame_tick are single-cycle strobes that are honoured only in the states
// that use them. The hit/suicide inputs are levels that are looked at only in PLAY.
module round_controller #(
  parameter int FRAME_DIV     = 4,
  parameter int EXPL_FRAMES   = 8,
  parameter int RESPAWN_TICKS = 60,
  parameter int WIN_SCORE     = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       p1_hit,
  input  logic       p2_hit,
  input  logic       p1_suicide,
  input  logic       p2_suicide,
  input  logic [9:0] p1x,
  input  logic [9:0] p1y,
  input  logic [9:0] p2x,
  input  logic [9:0] p2y,
  output logic [9:0] explosion_x,
  output logic [9:0] explosion_y,
  output logic [7:0] explosion_enum,
  output logic [7:0] scorep1,
  output logic [7:0] scorep2,
  output logic       freeze,
  output logic       respawn,
  output logic [1:0] winner,
  output logic [2:0] state
);

  localparam int TICK_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV + 1) : 1;
  localparam int RESP_W = (RESPAWN_TICKS > 1) ? $clog2(RESPAWN_TICKS + 1) : 1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PLAY     = 3'd1,
    ST_EXPLODE  = 3'd2,
    ST_RESPAWN  = 3'd3,
    ST_GAMEOVER = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        score1_q, score1_d;
  logic [7:0]        score2_q, score2_d;
  logic [7:0]        enum_q, enum_d;
  logic [9:0]        ex_q, ex_d;
  logic [9:0]        ey_q, ey_d;
  logic [1:0]        winner_q, winner_d;
  logic              respawn_q, respawn_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [RESP_W-1:0] resp_cnt_q, resp_cnt_d;

  logic p1_victim;
  logic p2_victim;
  logic frame_done;
  logic at_win;

  assign p1_victim  = p1_hit | p1_suicide;
  assign p2_victim  = p2_hit | p2_suicide;
  assign frame_done = (tick_cnt_q == TICK_W'(FRAME_DIV - 1));
  assign at_win     = (score1_q == 8'(WIN_SCORE)) || (score2_q == 8'(WIN_SCORE));

  // Next-state and datapath updates; every register holds unless its state acts on it.
  always_comb begin
    state_d    = state_q;
    score1_d   = score1_q;
    score2_d   = score2_q;
    enum_d     = enum_q;
    ex_d       = ex_q;
    ey_d       = ey_q;
    winner_d   = winner_q;
    respawn_d  = 1'b0;
    tick_cnt_d = tick_cnt_q;
    resp_cnt_d = resp_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_PLAY;
          respawn_d = 1'b1;
        end
      end
      ST_PLAY: begin
        if (p1_victim || p2_victim) begin
          state_d    = ST_EXPLODE;
          enum_d     = 8'd1;
          tick_cnt_d = '0;
          // A double knockout explodes at P1 and scores nobody.
          if (p1_victim) begin
            ex_d = p1x;
            ey_d = p1y;
          end else begin
            ex_d = p2x;
            ey_d = p2y;
          end
          if (p1_victim && !p2_victim && (score2_q < 8'(WIN_SCORE))) begin
            score2_d = score2_q + 8'd1;
          end
          if (p2_victim && !p1_victim && (score1_q < 8'(WIN_SCORE))) begin
            score1_d = score1_q + 8'd1;
          end
        end
      end
      ST_EXPLODE: begin
        if (frame_tick) begin
          if (frame_done) begin
            tick_cnt_d = '0;
            if (enum_q == 8'(EXPL_FRAMES)) begin
              enum_d     = 8'd0;
              state_d    = ST_RESPAWN;
              resp_cnt_d = '0;
            end else begin
              enum_d = enum_q + 8'd1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      ST_RESPAWN: begin
        if (frame_tick) begin
          if (resp_cnt_q == RESP_W'(RESPAWN_TICKS - 1)) begin
            resp_cnt_d = '0;
            if (at_win) begin
              state_d  = ST_GAMEOVER;
              winner_d = (score1_q == 8'(WIN_SCORE)) ? 2'b01 : 2'b10;
            end else begin
              state_d   = ST_PLAY;
              respawn_d = 1'b1;
            end
          end else begin
            resp_cnt_d = resp_cnt_q + 1'b1;
          end
        end
      end
      ST_GAMEOVER: begin
        if (start) begin
          state_d  = ST_IDLE;
          score1_d = 8'd0;
          score2_d = 8'd0;
          winner_d = 2'b00;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset clears the whole round.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      score1_q   <= 8'd0;
      score2_q   <= 8'd0;
      enum_q     <= 8'd0;
      ex_q       <= 10'd0;
      ey_q       <= 10'd0;
      winner_q   <= 2'b00;
      respawn_q  <= 1'b0;
      tick_cnt_q <= '0;
      resp_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      score1_q   <= score1_d;
      score2_q   <= score2_d;
      enum_q     <= enum_d;
      ex_q       <= ex_d;
      ey_q       <= ey_d;
      winner_q   <= winner_d;
      respawn_q  <= respawn_d;
      tick_cnt_q <= tick_cnt_d;
      resp_cnt_q <= resp_cnt_d;
    end
  end

  assign explosion_x    = ex_q;
  assign explosion_y    = ey_q;
  assign explosion_enum = enum_q;
  assign scorep1        = score1_q;
  assign scorep2        = score2_q;
  assign winner         = winner_q;
  assign respawn        = respawn_q;
  assign state          = state_q;
  assign freeze         = (state_q != ST_PLAY);

endmodule

// File: tb/tb_round_controller.sv
module tb_round_controller;

  localparam int FD = 4;
  localparam int EF = 8;
  localparam int RT = 60;
  localparam int WS = 5;

  localparam int PH_IDLE = 0, PH_PLAY = 1, PH_EXPLODE = 2, PH_RESPAWN = 3, PH_GAMEOVER = 4;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       frame_tick, start, p1_hit, p2_hit, p1_suicide, p2_suicide;
  logic [9:0] p1x, p1y, p2x, p2y;
  logic [9:0] explosion_x, explosion_y;
  logic [7:0] explosion_enum, scorep1, scorep2;
  logic       freeze, respawn;
  logic [1:0] winner;
  logic [2:0] state;

  round_controller #(
    .FRAME_DIV(FD), .EXPL_FRAMES(EF), .RESPAWN_TICKS(RT), .WIN_SCORE(WS)
  ) dut (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick), .start(start),
    .p1_hit(p1_hit), .p2_hit(p2_hit), .p1_suicide(p1_suicide), .p2_suicide(p2_suicide),
    .p1x(p1x), .p1y(p1y), .p2x(p2x), .p2y(p2y),
    .explosion_x(explosion_x), .explosion_y(explosion_y),
    .explosion_enum(explosion_enum), .scorep1(scorep1), .scorep2(scorep2),
    .freeze(freeze), .respawn(respawn), .winner(winner), .state(state)
  );

  // ---------------- scoreboard counters ----------------
  int n_vec;
  int n_err;

  task automatic chk(input string nm, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Explosion progress is tracked as total ticks since the hit; the frame
  // number is derived arithmetically from it.
  int m_phase, m_ticks, m_s1, m_s2, m_ex, m_ey, m_win, m_resp;

  task automatic model_reset();
    m_phase = PH_IDLE; m_ticks = 0; m_s1 = 0; m_s2 = 0;
    m_ex = 0; m_ey = 0; m_win = 0; m_resp = 0;
  endtask

  task automatic model_step();
    bit v1, v2;
    v1 = p1_hit | p1_suicide;
    v2 = p2_hit | p2_suicide;
    m_resp = 0;
    case (m_phase)
      PH_IDLE: if (start) begin m_phase = PH_PLAY; m_resp = 1; end
      PH_PLAY: if (v1 || v2) begin
        if (v1 && !v2) m_s2++;
        if (v2 && !v1) m_s1++;
        m_ex = v1 ? int'(p1x) : int'(p2x);
        m_ey = v1 ? int'(p1y) : int'(p2y);
        m_phase = PH_EXPLODE;
        m_ticks = 0;
      end
      PH_EXPLODE: if (frame_tick) begin
        m_ticks++;
        if (m_ticks == EF * FD) begin m_phase = PH_RESPAWN; m_ticks = 0; end
      end
      PH_RESPAWN: if (frame_tick) begin
        m_ticks++;
        if (m_ticks == RT) begin
          m_ticks = 0;
          if (m_s1 == WS || m_s2 == WS) begin
            m_phase = PH_GAMEOVER;
            m_win = (m_s1 == WS) ? 1 : 2;
          end else begin
            m_phase = PH_PLAY;
            m_resp = 1;
          end
        end
      end
      PH_GAMEOVER: if (start) begin
        m_phase = PH_IDLE; m_s1 = 0; m_s2 = 0; m_win = 0;
      end
      default: m_phase = PH_IDLE;
    endcase
  endtask

  function automatic int model_enum();
    return (m_phase == PH_EXPLODE) ? 1 + m_ticks / FD : 0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    frame_tick = 0; start = 0; p1_hit = 0; p2_hit = 0; p1_suicide = 0; p2_suicide = 0;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 0;
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int k = 0; k < n; k++) begin
      frame_tick = 1; step();
      frame_tick = 0; step();
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit       start, tick, p1h, p1s, p2h, p2s;
    int       p1x, p1y, p2x, p2y;
    int       reps;
    int       st, s1, s2, en, rsp, ex, ey;
  } vec_t;

  function automatic vec_t mk(input bit st_in, input bit tk, input bit [3:0] hits,
                              input int ax, input int ay, input int bx, input int by,
                              input int reps, input int st, input int s1, input int s2,
                              input int en, input int rsp, input int ex, input int ey);
    vec_t v;
    v.start = st_in; v.tick = tk;
    v.p1h = hits[3]; v.p1s = hits[2]; v.p2h = hits[1]; v.p2s = hits[0];
    v.p1x = ax; v.p1y = ay; v.p2x = bx; v.p2y = by; v.reps = reps;
    v.st = st; v.s1 = s1; v.s2 = s2; v.en = en; v.rsp = rsp; v.ex = ex; v.ey = ey;
    return v;
  endfunction

  vec_t vecs[13];

  initial begin
    n_vec = 0;
    n_err = 0;
    p1x = 100; p1y = 200; p2x = 300; p2y = 400;
    clear_inputs();
    model_reset();

    // ---- reset state, sampled while reset is held ----
    reset_n = 0;
    #2;
    chk("rst_state", state, 0);
    chk("rst_freeze", freeze, 1);
    chk("rst_score1", scorep1, 0);
    chk("rst_score2", scorep2, 0);
    chk("rst_enum", explosion_enum, 0);
    chk("rst_ex", explosion_x, 0);
    chk("rst_ey", explosion_y, 0);
    chk("rst_winner", winner, 0);
    chk("rst_respawn", respawn, 0);

    // ---- table-driven round ----
    //               start tk hits   p1x p1y p2x p2y reps st s1 s2 en rsp ex  ey
    vecs[0]  = mk(1, 0, 4'b0000, 100, 200, 300, 400,  1, 1, 0, 0, 0, 1,   0,   0);
    vecs[1]  = mk(0, 0, 4'b0000, 100, 200, 300, 400,  1, 1, 0, 0, 0, 0,   0,   0);
    vecs[2]  = mk(0, 0, 4'b1000, 100, 200, 300, 400,  1, 2, 0, 1, 1, 0, 100, 200);
    vecs[3]  = mk(0, 1, 4'b1000, 100, 200, 300, 400, 28, 2, 0, 1, 8, 0, 100, 200);
    vecs[4]  = mk(0, 1, 4'b1000, 100, 200, 300, 400,  4, 3, 0, 1, 0, 0, 100, 200);
    vecs[5]  = mk(0, 1, 4'b1000, 100, 200, 300, 400,  8, 3, 0, 1, 0, 0, 100, 200);
    vecs[6]  = mk(0, 1, 4'b0000, 100, 200, 300, 400, 51, 3, 0, 1, 0, 0, 100, 200);
    vecs[7]  = mk(0, 1, 4'b0000, 100, 200, 300, 400,  1, 1, 0, 1, 0, 1, 100, 200);
    vecs[8]  = mk(0, 0, 4'b0110,  11,  22,  33,  44,  1, 2, 0, 1, 1, 0,  11,  22);
    vecs[9]  = mk(0, 1, 4'b0000,  11,  22,  33,  44, 32, 3, 0, 1, 0, 0,  11,  22);
    vecs[10] = mk(1, 1, 4'b0000,  11,  22,  33,  44, 60, 1, 0, 1, 0, 1,  11,  22);
    vecs[11] = mk(0, 0, 4'b0010, 100, 200, 300, 400,  1, 2, 1, 1, 1, 0, 300, 400);
    vecs[12] = mk(1, 0, 4'b0010, 100, 200, 300, 400,  1, 2, 1, 1, 1, 0, 300, 400);

    @(posedge clk);
    #1;
    reset_n = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 13; i++) begin
      p1_hit = vecs[i].p1h; p1_suicide = vecs[i].p1s;
      p2_hit = vecs[i].p2h; p2_suicide = vecs[i].p2s;
      p1x = 10'(vecs[i].p1x); p1y = 10'(vecs[i].p1y);
      p2x = 10'(vecs[i].p2x); p2y = 10'(vecs[i].p2y);
      for (int r = 0; r < vecs[i].reps; r++) begin
        start = vecs[i].start; frame_tick = vecs[i].tick;
        step();
        if (r == vecs[i].reps - 1) begin
          chk($sformatf("v%0d_state", i), state, vecs[i].st);
          chk($sformatf("v%0d_freeze", i), freeze, (vecs[i].st == PH_PLAY) ? 0 : 1);
          chk($sformatf("v%0d_score1", i), scorep1, vecs[i].s1);
          chk($sformatf("v%0d_score2", i), scorep2, vecs[i].s2);
          chk($sformatf("v%0d_enum", i), explosion_enum, vecs[i].en);
          chk($sformatf("v%0d_respawn", i), respawn, vecs[i].rsp);
          chk($sformatf("v%0d_ex", i), explosion_x, vecs[i].ex);
          chk($sformatf("v%0d_ey", i), explosion_y, vecs[i].ey);
        end
        start = 0; frame_tick = 0;
        step();
      end
    end

    // ---- five P2-victim rounds to game over, then back to idle ----
    p1x = 100; p1y = 200; p2x = 300; p2y = 400;
    do_reset();
    start = 1; step(); start = 0;
    for (int rnd = 1; rnd <= 5; rnd++) begin
      p2_hit = 1; step(); p2_hit = 0;
      chk("go_hit_score1", scorep1, rnd);
      tick_n(EF * FD);
      tick_n(RT);
      if (rnd < 5) chk("go_round_state", state, PH_PLAY);
    end
    chk("go_state", state, PH_GAMEOVER);
    chk("go_winner", winner, 1);
    chk("go_score1", scorep1, 5);
    chk("go_score2", scorep2, 0);
    chk("go_freeze", freeze, 1);
    p1_hit = 1; tick_n(3); p1_hit = 0;
    chk("go_hold_winner", winner, 1);
    chk("go_hold_score2", scorep2, 0);
    start = 1; step(); start = 0;
    chk("go_exit_state", state, PH_IDLE);
    chk("go_exit_score1", scorep1, 0);
    chk("go_exit_winner", winner, 0);

    // ---- asynchronous reset during explosion frame 4 ----
    do_reset();
    start = 1; step(); start = 0;
    p1_hit = 1; step(); p1_hit = 0;
    tick_n(12);
    chk("ar_enum_pre", explosion_enum, 4);
    chk("ar_score2_pre", scorep2, 1);
    #2;
    reset_n = 0;
    #1;
    chk("ar_state", state, PH_IDLE);
    chk("ar_enum", explosion_enum, 0);
    chk("ar_score2", scorep2, 0);
    chk("ar_ex", explosion_x, 0);
    chk("ar_freeze", freeze, 1);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1;
    tick_n(2);
    chk("ar_idle_hold", state, PH_IDLE);

    // ---- randomized play against the reference model ----
    do_reset();
    for (int c = 0; c < 8000; c++) begin
      start      = ($urandom_range(0, 29) == 0);
      frame_tick = ($urandom_range(0, 1) == 1);
      p1_hit     = ($urandom_range(0, 24) == 0);
      p2_hit     = ($urandom_range(0, 24) == 0);
      p1_suicide = ($urandom_range(0, 49) == 0);
      p2_suicide = ($urandom_range(0, 49) == 0);
      p1x = 10'($urandom_range(0, 1023)); p1y = 10'($urandom_range(0, 1023));
      p2x = 10'($urandom_range(0, 1023)); p2y = 10'($urandom_range(0, 1023));
      step();
      chk("rnd_state", state, m_phase);
      chk("rnd_score1", scorep1, m_s1);
      chk("rnd_score2", scorep2, m_s2);
      chk("rnd_enum", explosion_enum, model_enum());
      chk("rnd_ex", explosion_x, m_ex);
      chk("rnd_ey", explosion_y, m_ey);
      chk("rnd_winner", winner, m_win);
      chk("rnd_respawn", respawn, m_resp);
      chk("rnd_freeze", freeze, (m_phase == PH_PLAY) ? 0 : 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/round_controller.md
ROUND_CONTROLLER -- requirements
Module: round_controller

Interface
REQ-001 Parameter FRAME_DIV, default 4: frame_tick pulses per explosion animation frame.
REQ-002 Parameter EXPL_FRAMES, default 8: explosion animation frames, numbered 1..EXPL_FRAMES.
REQ-003 Parameter RESPAWN_TICKS, default 60: frame_tick pulses spent in RESPAWN.
REQ-004 Parameter WIN_SCORE, default 5, legal range 1..99: score that ends the match.
REQ-005 clk  in  1  system clock, 50 MHz; single clock domain.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 frame_tick  in  1  one-cycle pulse per video frame, synchronous to clk.
REQ-008 start  in  1  one-cycle pulse from the start/fire key.
REQ-009 p1_hit, p2_hit  in  1 each  player struck by opponent missile; level.
REQ-010 p1_suicide, p2_suicide  in  1 each  player struck by own missile; level.
REQ-011 p1x, p1y, p2x, p2y  in  10 each  player sprite positions.
REQ-012 explosion_x, explosion_y  out  10 each  latched explosion position.
REQ-013 explosion_enum  out  8  explosion frame index; 0 = no explosion.
REQ-014 scorep1, scorep2  out  8 each  binary scores for the score ROM.
REQ-015 freeze  out  1  high = player/missile motion disabled.
REQ-016 respawn  out  1  one-cycle pulse commanding position/missile reinit.
REQ-017 winner  out  2  00 none, 01 P1, 10 P2.
REQ-018 state  out  3  IDLE=0, PLAY=1, EXPLODE=2, RESPAWN=3, GAMEOVER=4.

Function
REQ-019 FSM SHALL have states IDLE, PLAY, EXPLODE, RESPAWN, GAMEOVER; all registers update on rising clk only.
REQ-020 IDLE: start -> PLAY with respawn pulsed in the same transition cycle; frame_tick and hit inputs ignored.
REQ-021 PLAY: victim set sampled each cycle; P1 victim = p1_hit|p1_suicide; P2 victim = p2_hit|p2_suicide.
REQ-022 PLAY, only P1 victim: scorep2 += 1, explosion_x/y <= p1x/p1y, next state EXPLODE.
REQ-023 PLAY, only P2 victim: scorep1 += 1, explosion_x/y <= p2x/p2y, next state EXPLODE.
REQ-024 PLAY, both victims in same cycle: no score change, explosion at P1 position, EXPLODE.
REQ-025 On PLAY->EXPLODE, explosion_enum SHALL be 1 on the next cycle; tick counter cleared.
REQ-026 EXPLODE: each frame_tick increments tick counter; at FRAME_DIV ticks counter clears and enum increments.
REQ-027 EXPLODE: tick that completes frame EXPL_FRAMES -> RESPAWN, enum <= 0; total duration EXPL_FRAMES*FRAME_DIV ticks.
REQ-028 RESPAWN: counts frame_ticks; on RESPAWN_TICKS-th tick: if scorep1 or scorep2 == WIN_SCORE -> GAMEOVER, else PLAY with respawn pulsed.
REQ-029 GAMEOVER: winner = 01 if scorep1 == WIN_SCORE, 10 if scorep2 == WIN_SCORE; held until exit.
REQ-030 GAMEOVER: start -> IDLE, scores cleared, winner <= 00.
REQ-031 Hit inputs outside PLAY SHALL be ignored (no double scoring while victim input stays high).
REQ-032 start outside IDLE/GAMEOVER SHALL be ignored; start and frame_tick coincident are both honoured per state.
REQ-033 freeze = 1 in every state except PLAY; combinational from state register.
REQ-034 explosion_x/y SHALL hold last latched value outside EXPLODE.
REQ-035 Scores never exceed WIN_SCORE; increments are 8-bit unsigned, no wrap possible.
REQ-036 Counters sized for parameter maxima; unreachable state encodings -> IDLE next cycle.

Reset
REQ-037 reset_n low SHALL immediately force: state IDLE, scores 0, explosion_enum 0, explosion_x/y 0, winner 00, respawn 0, counters 0, freeze 1.
REQ-038 Reset asserted mid-EXPLODE or mid-RESPAWN SHALL abort the round with no score retained; release returns to IDLE awaiting start.

Verification
REQ-039 Reset, start pulse -> state PLAY next cycle, respawn high one cycle, freeze 0.
REQ-040 PLAY, p1_hit=1 with p1x=100,p1y=200 -> next cycle scorep2=1, enum=1, explosion=(100,200), freeze=1; p1_hit held high 40 ticks gives no further scoring.
REQ-041 Defaults: enum reaches 8 after 28 ticks, returns 0 at tick 32 (RESPAWN); PLAY plus respawn pulse at 60th subsequent tick.
REQ-042 p1_suicide and p2_hit same cycle -> both scores unchanged, explosion at P1 position.
REQ-043 Five P2-victim rounds -> scorep1=5, after last RESPAWN state GAMEOVER, winner=01; start -> IDLE, scores 0.
REQ-044 reset_n pulsed low at explosion frame 4 -> asynchronously IDLE, enum 0, scores 0.
